key_event_fifo: RTL and testbench
=================================

Name: key_event_fifo

Overview:
- Memory-mapped key/switch input device, successor to the single-register key port.
- Synchronises a KEY_WIDTH-bit input and detects masked changes.
- Queues each changed snapshot in a DEPTH-entry FIFO so bursts of key activity are not lost.
- Exposes data, control/status and mask registers on the shared data bus, plus a level interrupt to the CPU interrupt controller.

Parameters:
- KEY_WIDTH, 4, width of the key input and of each FIFO entry (1..BITS).
- BITS, 32, data/address bus width (>= 24).
- DEPTH, 8, FIFO entries; power of two, 2..128.
- BASE, 32'hF0000010, data register address.
- CTRL_BASE, 32'hF0000110, control/status register address.
- MASK_BASE, 32'hF0000210, change-mask register address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  bus write strobe.
- re  input  1  bus read strobe.
- memAddr  input  BITS  bus address.
- dataBusIn  input  BITS  write data.
- key  input  KEY_WIDTH  raw asynchronous key levels.
- dataBusOut  output  BITS  read data; all zeros when not selected.
- irq  output  1  interrupt request, level.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync1, sync2 and prev cleared to 0; FIFO empty (rd_ptr=wr_ptr=count=0).
  - overrun=0, IE=0, mask = all ones.
  - Outputs: dataBusOut=0, irq=0.
- Synchronizer: sync1<=key, sync2<=sync1, prev<=sync2, every cycle.
- Change detect: change = |((sync2 ^ prev) & mask), evaluated combinationally.
  - A key edge present before clock edge k enters the FIFO at edge k+2.
  - ready is visible after that edge.
  - A nonzero key held through reset generates one event after reset release.
- Push: on change, write sync2 into fifo[wr_ptr], then wr_ptr++ and count++.
  - Pointers wrap modulo DEPTH.
- Pop: occurs on data_rd = re & !we & (memAddr==BASE) & (count!=0).
  - dataBusOut = zero-extended fifo[rd_ptr] in the same cycle (combinational).
  - rd_ptr++ and count-- at the clock edge.
- Read of empty data register: returns 0; no pointer change; no error flag.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - When full (count==DEPTH), the push is accepted because a slot frees the same cycle; overrun is not set.
- Full and push without pop: entry dropped, FIFO unchanged, overrun<=1.
- Overrun is sticky; cleared only by a CTRL write with dataBusIn[2]=0.
  - A set and a clear in the same cycle: set wins.
- Control register (read at CTRL_BASE with re & !we):
  - bit0 ready = (count!=0)
  - bit1 full = (count==DEPTH)
  - bit2 overrun
  - bit8 IE
  - bits[23:16] count, zero-extended
  - all other bits 0
- Control write (we & memAddr==CTRL_BASE):
  - IE<=dataBusIn[8].
  - Overrun handled as above.
  - Writing bit0/bit1 has no effect.
- Mask register:
  - Write: we & MASK_BASE loads dataBusIn[KEY_WIDTH-1:0].
  - Read returns the mask zero-extended.
  - The new mask affects change detection from the next cycle.
- Writes to BASE are ignored.
- dataBusOut is 0 whenever:
  - we=1, or
  - re=0, or
  - the address matches none of the three registers.
- irq = IE & (ready | overrun), registered-state driven, no extra latency.
- count width = log2(DEPTH)+1 bits; never exceeds DEPTH, never underflows.

Test Plan:
- Reset then key=4'b0000 for 10 cycles -> CTRL reads 0; irq=0.
- Release reset, then key 0->4'b0101 at cycle 2:
  - CTRL bit0=1 and count=1 appear 2 edges later.
  - DATA read returns 32'h5.
  - CTRL then reads 0.
- With mask=4'b0001, toggle key bit2 only -> no event; count stays 0. Then toggle bit0 -> one event queued.
- Generate 9 distinct changes with DEPTH=8 and no reads:
  - CTRL = 32'h0008_0007 (count 8, full, ready, overrun).
  - 8 DATA reads return the first 8 snapshots in order.
  - Write CTRL 0 -> overrun cleared.
- With FIFO full, issue a DATA read in the same cycle as a new change:
  - count stays 8; overrun=0.
  - Last entry equals the new snapshot.
- Write CTRL 32'h100 with one entry queued -> irq=1. Pop it -> irq=0 next cycle. Assert reset mid-burst -> all state zeroed and irq=0 immediately.

Source files
------------

// File: rtl/key_event_fifo.sv
// key_event_fifo: memory-mapped key/switch port. Synchronises the key
// inputs, detects masked level changes and queues each changed snapshot
// in a small FIFO. The CPU drains it through the data register, and the
// control/status and mask registers sit alongside it on the same bus.
module key_event_fifo #(
  parameter int KEY_WIDTH = 4,
  parameter int BITS      = 32,
  parameter int DEPTH     = 8,
  parameter logic [BITS-1:0] BASE      = 32'hF0000010,
  parameter logic [BITS-1:0] CTRL_BASE = 32'hF0000110,
  parameter logic [BITS-1:0] MASK_BASE = 32'hF0000210
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [BITS-1:0]      memAddr,
  input  logic [BITS-1:0]      dataBusIn,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [BITS-1:0]      dataBusOut,
  output logic                 irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [KEY_WIDTH-1:0] sync1, sync2, prev;
  logic [KEY_WIDTH-1:0] mask;
  logic [KEY_WIDTH-1:0] fifo [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 overrun, ie;

  logic change, ready, full;
  logic data_rd, push, drop, ctrl_wr, mask_wr;
  logic [BITS-1:0] status_word, data_word, mask_word;
  logic unused_bits;

  // Change detection and bus strobe decode.
  always_comb begin
    change  = |((sync2 ^ prev) & mask);
    ready   = (count != '0);
    full    = (count == FULL_CNT);
    data_rd = re & ~we & (memAddr == BASE) & ready;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    push    = change & (~full | data_rd);
    drop    = change & full & ~data_rd;
    ctrl_wr = we & (memAddr == CTRL_BASE);
    mask_wr = we & (memAddr == MASK_BASE);
  end

  // Two-flop synchroniser plus the previous-sample register for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FIFO storage; contents are only observable while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= sync2;
  end

  // Pointers and occupancy; pointer wrap is natural as DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (data_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, data_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Control and mask registers; a dropped entry beats a same-cycle overrun clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
      ie      <= 1'b0;
      mask    <= '1;
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (ctrl_wr && !dataBusIn[2])
        overrun <= 1'b0;
      if (ctrl_wr) ie   <= dataBusIn[8];
      if (mask_wr) mask <= dataBusIn[KEY_WIDTH-1:0];
    end
  end

  // Register images presented on the read path.
  always_comb begin
    status_word             = '0;
    status_word[0]          = ready;
    status_word[1]          = full;
    status_word[2]          = overrun;
    status_word[8]          = ie;
    status_word[16 +: CNT_W] = count;
    data_word               = '0;
    if (ready) data_word[KEY_WIDTH-1:0] = fifo[rd_ptr];
    mask_word               = '0;
    mask_word[KEY_WIDTH-1:0] = mask;
  end

  // Read mux; the bus sees zeros unless this device is being read.
  always_comb begin
    dataBusOut = '0;
    if (re && !we) begin
      if (memAddr == BASE)           dataBusOut = data_word;
      else if (memAddr == CTRL_BASE) dataBusOut = status_word;
      else if (memAddr == MASK_BASE) dataBusOut = mask_word;
    end
  end

  // Level interrupt straight from registered state.
  always_comb begin
    irq = ie & (ready | overrun);
  end

  // Upper write-data bits have no register behind them.
  assign unused_bits = ^dataBusIn;

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo: directed scenarios plus randomized traffic,
// checked by a scoreboard against a queue-based reference model.
module tb_key_event_fifo;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_DATA = 32'hF0000010;
  localparam logic [31:0] A_CTRL = 32'hF0000110;
  localparam logic [31:0] A_MASK = 32'hF0000210;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  key = '0;
  logic [31:0] data_out;
  logic        irq;

  key_event_fifo #(
    .KEY_WIDTH(4), .BITS(32), .DEPTH(DEPTH),
    .BASE(A_DATA), .CTRL_BASE(A_CTRL), .MASK_BASE(A_MASK)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(mem_addr),
    .dataBusIn(data_in), .key(key), .dataBusOut(data_out), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];

  always @(negedge clk) begin
    if (re && !we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %h expected no read", data_out);
      end else begin
        logic [31:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, data_out, e);
      end
    end else begin
      chk("idle_bus_zero", data_out, 32'h0);
    end
  end

  // Reference model: a queue of snapshots plus flag bits
  logic [3:0] m_fifo[$];
  bit         m_ovr, m_ie;
  logic [3:0] m_mask, m_key;

  function automatic logic [31:0] m_ctrl();
    logic [31:0] r;
    r        = '0;
    r[0]     = (m_fifo.size() != 0);
    r[1]     = (m_fifo.size() == DEPTH);
    r[2]     = m_ovr;
    r[8]     = m_ie;
    r[23:16] = 8'(m_fifo.size());
    return r;
  endfunction

  task automatic model_change(input logic [3:0] v);
    if (((m_key ^ v) & m_mask) != 4'h0) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
      else m_ovr = 1'b1;
    end
    m_key = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_exp(input logic [31:0] addr, input logic [31:0] exp, input string name);
    mem_addr = addr;
    re = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    re = 1'b0;
    mem_addr = '0;
  endtask

  task automatic rd(input logic [31:0] addr);
    logic [31:0] e;
    string nm;
    e = '0;
    if (addr == A_DATA) begin
      nm = "data_rd";
      if (m_fifo.size() != 0) e = {28'h0, m_fifo.pop_front()};
    end else if (addr == A_CTRL) begin
      nm = "ctrl_rd";
      e = m_ctrl();
    end else begin
      nm = "mask_rd";
      e = {28'h0, m_mask};
    end
    read_exp(addr, e, nm);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    mem_addr = addr;
    data_in = d;
    we = 1'b1;
    tick();
    we = 1'b0;
    data_in = '0;
    mem_addr = '0;
    if (addr == A_CTRL) begin
      m_ie = d[8];
      if (!d[2]) m_ovr = 1'b0;
    end else if (addr == A_MASK) begin
      m_mask = d[3:0];
    end
  endtask

  task automatic set_key(input logic [3:0] v);
    key = v;
    model_change(v);
    repeat (3) tick();
  endtask

  task automatic chk_irq(input string name);
    chk(name, {31'h0, irq}, {31'h0, m_ie && (m_fifo.size() != 0 || m_ovr)});
  endtask

  task automatic release_reset();
    reset = 1'b1;
    m_fifo.delete();
    m_ovr  = 1'b0;
    m_ie   = 1'b0;
    m_mask = 4'hF;
    m_key  = 4'h0;
    model_change(key);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    int op;

    // Reset with idle keys
    reset = 1'b0;
    key = 4'h0;
    repeat (3) tick();
    chk("irq_in_reset", {31'h0, irq}, 32'h0);
    release_reset();
    repeat (10) tick();
    read_exp(A_CTRL, 32'h0, "ctrl_after_reset");
    chk_irq("irq_after_reset");

    // Edge-to-ready latency
    key = 4'h5;
    read_exp(A_CTRL, 32'h0, "lat_edge_k");
    read_exp(A_CTRL, 32'h0, "lat_edge_k1");
    read_exp(A_CTRL, 32'h0, "lat_edge_k2");
    model_change(4'h5);
    read_exp(A_CTRL, 32'h0001_0001, "lat_ready");
    m_fifo.pop_front();
    read_exp(A_DATA, 32'h5, "lat_data");
    read_exp(A_CTRL, 32'h0, "lat_empty");
    read_exp(A_DATA, 32'h0, "empty_data_rd");

    // Mask filtering
    wr(A_MASK, 32'hFFFF_FFF1);
    rd(A_MASK);
    set_key(4'h1);
    read_exp(A_CTRL, 32'h0, "mask_blocks");
    set_key(4'h0);
    rd(A_CTRL);
    rd(A_DATA);
    // Simultaneous re and we: write wins, bus stays zero
    mem_addr = A_MASK; data_in = 32'hF; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0; data_in = '0; mem_addr = '0;
    m_mask = 4'hF;
    rd(A_MASK);

    // Overflow: nine changes into eight slots
    for (int i = 1; i <= 9; i++) set_key(4'(i));
    read_exp(A_CTRL, 32'h0008_0007, "full_overrun");
    m_ovr = 1'b1;
    for (int i = 0; i < 8; i++) rd(A_DATA);
    rd(A_CTRL);
    wr(A_CTRL, 32'h0);
    rd(A_CTRL);

    // Full FIFO: pop coincides with a push
    for (int i = 1; i <= 8; i++) set_key(4'(i));
    read_exp(A_CTRL, 32'h0008_0003, "refill_full");
    key = 4'hA;
    tick();
    tick();
    e = {28'h0, m_fifo.pop_front()};
    read_exp(A_DATA, e, "full_pop_push");
    m_fifo.push_back(4'hA);
    m_key = 4'hA;
    read_exp(A_CTRL, 32'h0008_0003, "full_no_overrun");
    for (int i = 0; i < 7; i++) rd(A_DATA);
    read_exp(A_DATA, 32'hA, "last_is_new");
    m_fifo.pop_front();

    // Interrupt enable
    set_key(4'h3);
    wr(A_CTRL, 32'h100);
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd(A_DATA);
    chk("irq_clear", {31'h0, irq}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1:    set_key(4'($urandom_range(0, 15)));
        2:       rd(A_DATA);
        3:       rd(A_CTRL);
        4:       wr(A_MASK, (($urandom_range(0, 3) == 0) ? $urandom : 32'hF));
        5:       wr(A_CTRL, $urandom);
        6:       rd(A_MASK);
        default: rd(A_DATA);
      endcase
      chk_irq("irq_rand");
    end

    // Reset in the middle of a burst
    wr(A_MASK, 32'hF);
    wr(A_CTRL, 32'h104);
    set_key(~m_key);
    key = ~key;
    tick();
    chk("irq_before_reset", {31'h0, irq}, 32'h1);
    reset = 1'b0;
    #1;
    chk("irq_reset_immediate", {31'h0, irq}, 32'h0);
    read_exp(A_CTRL, 32'h0, "ctrl_in_reset");
    tick();
    key = 4'h6;
    release_reset();
    rd(A_CTRL);
    rd(A_MASK);
    rd(A_DATA);
    rd(A_CTRL);
    chk_irq("irq_final");

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL pending_reads: got %0d expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
